mc_controller: RTL

- Multicycle control unit for the 32-bit MIPS datapath; one instruction is sequenced over 3–5 clocks through a Moore FSM.
- Inputs are `opcode`, `func` and `ALUZero` from the datapath. Outputs are every datapath control strobe and select.
- Top level ties datapath `PCinit` to `rst`.

---
 rtl/mc_controller.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing each
// instruction over 3-5 clocks and driving every datapath strobe.
module mc_controller #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       ALUZero,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BrFlag,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       WRsel,
    output logic       WDsel,
    output logic       MemtoReg,
    output logic       ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOperation,
    output logic       illegal,
    output logic       halted
);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_RTYPE_EX,
        S_RTYPE_WB,
        S_IMM_EX,
        S_IMM_WB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR,
        S_HALT
    } state_t;

    state_t     state;
    state_t     next;
    state_t     dec_next;
    logic       dec_bad;
    logic       dec_bne;
    logic       dec_sw;
    logic [2:0] dec_op;
    logic       br_ne;
    logic       mem_sw;
    logic [2:0] alu_q;

    // Instruction classification, consulted only while in DECODE
    always_comb begin
        dec_next = S_FETCH;
        dec_bad  = 1'b0;
        dec_bne  = 1'b0;
        dec_sw   = 1'b0;
        dec_op   = ALU_ADD;
        unique case (opcode)
            OP_R: begin
                dec_next = S_RTYPE_EX;
                unique case (func)
                    FN_ADD:  dec_op = ALU_ADD;
                    FN_SUB:  dec_op = ALU_SUB;
                    FN_AND:  dec_op = ALU_AND;
                    FN_OR:   dec_op = ALU_OR;
                    FN_SLT:  dec_op = ALU_SLT;
                    FN_JR:   dec_next = S_JR;
                    default: dec_bad = 1'b1;
                endcase
            end
            OP_LW:   dec_next = S_MEMADR;
            OP_SW: begin
                dec_next = S_MEMADR;
                dec_sw   = 1'b1;
            end
            OP_ADDI: dec_next = S_IMM_EX;
            OP_SLTI: begin
                dec_next = S_IMM_EX;
                dec_op   = ALU_SLT;
            end
            OP_ANDI: begin
                dec_next = S_IMM_EX;
                dec_op   = ALU_AND;
            end
            OP_BEQ:  dec_next = S_BRANCH;
            OP_BNE: begin
                dec_next = S_BRANCH;
                dec_bne  = 1'b1;
            end
            OP_J:    dec_next = S_JUMP;
            OP_JAL:  dec_next = S_JAL;
            default: dec_bad = 1'b1;
        endcase
        if (dec_bad) begin
            dec_next = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_FETCH;
            br_ne  <= 1'b0;
            mem_sw <= 1'b0;
            alu_q  <= ALU_ADD;
        end else begin
            state <= next;
            if (state == S_DECODE) begin
                br_ne  <= dec_bne;
                mem_sw <= dec_sw;
                alu_q  <= dec_op;
            end
        end
    end

    // Outputs are forced low for as long as reset is held
    always_comb begin
        next         = S_FETCH;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        BrFlag       = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        WRsel        = 1'b0;
        WDsel        = 1'b0;
        MemtoReg     = 1'b0;
        ALUsrcA      = 1'b0;
        ALUsrcB      = 2'b00;
        PCSrc        = 2'b00;
        ALUOperation = ALU_AND;
        illegal      = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            unique case (state)
                S_FETCH: begin
                    MemRead      = 1'b1;
                    IRWrite      = 1'b1;
                    ALUsrcB      = 2'b01;
                    ALUOperation = ALU_ADD;
                    PCWrite      = 1'b1;
                    next         = S_DECODE;
                end
                S_DECODE: begin
                    ALUsrcB      = 2'b11;
                    ALUOperation = ALU_ADD;
                    illegal      = dec_bad;
                    next         = dec_next;
                end
                S_RTYPE_EX: begin
                    ALUsrcA      = 1'b1;
                    ALUOperation = alu_q;
                    next         = S_RTYPE_WB;
                end
                S_RTYPE_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_IMM_EX: begin
                    ALUsrcA      = 1'b1;
                    ALUsrcB      = 2'b10;
                    ALUOperation = alu_q;
                    next         = S_IMM_WB;
                end
                S_IMM_WB: RegWrite = 1'b1;
                S_MEMADR: begin
                    ALUsrcA      = 1'b1;
                    ALUsrcB      = 2'b10;
                    ALUOperation = ALU_ADD;
                    next         = mem_sw ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                    next    = S_MEMWB;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUsrcA      = 1'b1;
                    ALUOperation = ALU_SUB;
                    PCWriteCond  = 1'b1;
                    PCSrc        = 2'b01;
                    BrFlag       = br_ne ? ~ALUZero : ALUZero;
                end
                S_JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'b10;
                end
                S_JAL: begin
                    PCWrite  = 1'b1;
                    PCSrc    = 2'b10;
                    RegWrite = 1'b1;
                    WRsel    = 1'b1;
                    WDsel    = 1'b1;
                end
                S_JR: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'b11;
                end
                S_HALT: begin
                    halted = 1'b1;
                    next   = S_HALT;
                end
                default: next = S_FETCH;
            endcase
        end
    end

endmodule
